// File: rtl/uart_tx_engine_p_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_p_pkg
// Shared definitions for the UART transmit engine:
//   - default DATA_W / STOP_BITS / BAUD_W values
//   - IDLE/SHIFT state constants
//   - frame_len() helper: total bits per frame (start + data + bit9 + bit10 + stops)
// -----------------------------------------------------------------------------
package uart_tx_engine_p_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_STOP_BITS = 1;
    localparam int DEF_BAUD_W    = 19;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Start bit + (data_w-1) data bits + bit9 + bit10 + stop bits.
    function automatic int frame_len(input int data_w, input int stop_bits);
        return data_w + 2 + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_engine_p_parity.sv
// -----------------------------------------------------------------------------
// tx_parity_gen
// Combinational decode of the two bits that follow the low DATA_W-1 data bits.
// Ports:
//   i_eight  : 1 = full DATA_W word, 0 = short (DATA_W-1 bits)
//   i_pen    : parity enable
//   i_ohel   : 0 = even parity, 1 = odd parity
//   i_ldata  : word being sent
//   o_bit9   : data MSB, parity, or mark depending on mode
//   o_bit10  : parity or mark depending on mode
// -----------------------------------------------------------------------------
module tx_parity_gen #(
    parameter int DATA_W = 8
) (
    input  logic              i_eight,
    input  logic              i_pen,
    input  logic              i_ohel,
    input  logic [DATA_W-1:0] i_ldata,
    output logic              o_bit9,
    output logic              o_bit10
);

    // Even parity is the XOR of the covered bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic w_p_short;
    logic w_p_full;

    // Short mode covers only the low DATA_W-1 bits; the MSB is masked to zero.
    assign w_p_short = parity_bit({1'b0, i_ldata[DATA_W-2:0]}, i_ohel);
    assign w_p_full  = parity_bit(i_ldata, i_ohel);

    // Select bit9/bit10 from the mode bits; mark (1) wherever nothing else applies.
    always_comb begin
        o_bit9  = 1'b1;
        o_bit10 = 1'b1;
        case ({i_eight, i_pen})
            2'b00: begin
                o_bit9  = 1'b1;
                o_bit10 = 1'b1;
            end
            2'b01: begin
                o_bit9  = w_p_short;
                o_bit10 = 1'b1;
            end
            2'b10: begin
                o_bit9  = i_ldata[DATA_W-1];
                o_bit10 = 1'b1;
            end
            2'b11: begin
                o_bit9  = i_ldata[DATA_W-1];
                o_bit10 = w_p_full;
            end
            default: begin
                o_bit9  = 1'b1;
                o_bit10 = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_engine_p.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_p
// UART transmit engine: on a load handshake latches a word plus frame config,
// builds the frame (start, data, bit9, bit10, stop bits) and shifts it out
// LSB-first, each bit held for max(baud_k,1) clocks.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high
//   baud_k  : clocks per bit (0 treated as 1)
//   eight   : 1 = DATA_W data bits, 0 = DATA_W-1
//   pen     : parity enable
//   ohel    : 0 = even, 1 = odd parity
//   ldata   : word to send
//   load    : request, accepted only while txrdy=1
//   tx      : serial line, idle high
//   txrdy   : idle / ready for load
//   done    : one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module uart_tx_engine_p
    import uart_tx_engine_p_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STOP_BITS = DEF_STOP_BITS,
    parameter int BAUD_W    = DEF_BAUD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BAUD_W-1:0] baud_k,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [DATA_W-1:0] ldata,
    input  logic              load,
    output logic              tx,
    output logic              txrdy,
    output logic              done
);

    localparam int N  = frame_len(DATA_W, STOP_BITS);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    logic [0:0]        r_state;
    logic [N-1:0]      r_shift;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BAUD_W-1:0] r_kmax;
    logic [CW-1:0]     r_bit_cnt;
    logic              r_txrdy;
    logic              r_done;

    logic              w_bit9;
    logic              w_bit10;
    logic [N-1:0]      w_frame;
    logic              w_accept;
    logic [BAUD_W-1:0] w_kmax;
    logic              w_baud_wrap;
    logic              w_last_bit;

    tx_parity_gen #(
        .DATA_W (DATA_W)
    ) u_parity (
        .i_eight (eight),
        .i_pen   (pen),
        .i_ohel  (ohel),
        .i_ldata (ldata),
        .o_bit9  (w_bit9),
        .o_bit10 (w_bit10)
    );

    // Frame image, LSB is the first bit on the wire (start bit).
    assign w_frame  = {{STOP_BITS{1'b1}}, w_bit10, w_bit9, ldata[DATA_W-2:0], 1'b0};
    assign w_accept = load & r_txrdy;

    // Terminal baud count is k-1, with baud_k=0 behaving like baud_k=1.
    assign w_kmax = (baud_k == {BAUD_W{1'b0}}) ? {BAUD_W{1'b0}} : (baud_k - BAUD_W'(1));

    // Compare with >= so a corrupted counter still reaches a boundary / IDLE.
    assign w_baud_wrap = (r_baud_cnt >= r_kmax);
    assign w_last_bit  = (r_bit_cnt >= LAST_BIT);

    // tx is taken straight from the shift register so it is a registered output.
    assign tx    = r_shift[0];
    assign txrdy = r_txrdy;
    assign done  = r_done;

    // IDLE/SHIFT sequencer with baud timer, bit counter and serializer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= {N{1'b1}};
            r_baud_cnt <= {BAUD_W{1'b0}};
            r_kmax     <= {BAUD_W{1'b0}};
            r_bit_cnt  <= {CW{1'b0}};
            r_txrdy    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state    <= ST_SHIFT;
                        r_shift    <= w_frame;
                        r_kmax     <= w_kmax;
                        r_baud_cnt <= {BAUD_W{1'b0}};
                        r_bit_cnt  <= {CW{1'b0}};
                        r_txrdy    <= 1'b0;
                    end else begin
                        r_shift <= {N{1'b1}};
                        r_txrdy <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_done <= 1'b0;
                    if (w_baud_wrap) begin
                        r_baud_cnt <= {BAUD_W{1'b0}};
                        if (w_last_bit) begin
                            // Frame complete: line back to mark, ready raised, done pulsed.
                            r_state   <= ST_IDLE;
                            r_shift   <= {N{1'b1}};
                            r_bit_cnt <= {CW{1'b0}};
                            r_txrdy   <= 1'b1;
                            r_done    <= 1'b1;
                        end else begin
                            r_shift   <= {1'b1, r_shift[N-1:1]};
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_shift <= {N{1'b1}};
                    r_txrdy <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
